coin_eject_sequencer: RTL and testbench

COIN_EJECT_SEQUENCER -- requirements
Module: coin_eject_sequencer

---
 rtl/coin_eject_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_coin_eject_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/coin_eject_sequencer.sv
// Coin eject sequencer: pays out a change amount using quarters, dimes and
// nickels, one coin at a time. Each coin is commanded with a one-cycle
// solenoid pulse, and the sequencer waits for the mechanism to acknowledge
// the drop. A missing acknowledge aborts the sequence and sets a sticky
// timeout flag. Any cents that cannot be paid are reported as shortfall.
module coin_eject_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] amount,
  input  logic       tube_empty_q,
  input  logic       tube_empty_d,
  input  logic       tube_empty_n,
  input  logic       eject_ack,
  output logic       eject_q,
  output logic       eject_d,
  output logic       eject_n,
  output logic       busy,
  output logic       done,
  output logic [8:0] shortfall,
  output logic [6:0] ncoins,
  output logic       err_timeout
);

  // The counter only has to reach ACK_TIMEOUT-1, which is the last
  // acknowledge-wait cycle. Its width is at least one bit.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = (ACK_TIMEOUT < 1) ? {CW{1'b0}} : CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_EJECT    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_Q    = 2'd1,
    COIN_D    = 2'd2,
    COIN_N    = 2'd3
  } coin_t;

  state_t        state_r;
  coin_t         coin_r;
  logic [8:0]    remaining_r;
  logic [CW-1:0] wait_cnt_r;

  coin_t         pick_s;
  logic [8:0]    coin_val_s;
  logic [8:0]    rem_after_s;
  logic [6:0]    ncoins_inc_s;

  // Pick the largest coin that fits in the remaining amount and whose tube
  // still holds coins. The value test is what prevents underflow later.
  function automatic coin_t pick_coin(input logic [8:0] rem,
                                      input logic       empty_q,
                                      input logic       empty_d,
                                      input logic       empty_n);
    coin_t c;
    c = COIN_NONE;
    if (!empty_q && (rem >= 9'd25)) begin
      c = COIN_Q;
    end else if (!empty_d && (rem >= 9'd10)) begin
      c = COIN_D;
    end else if (!empty_n && (rem >= 9'd5)) begin
      c = COIN_N;
    end else begin
      c = COIN_NONE;
    end
    return c;
  endfunction

  // Face value in cents of a coin code.
  function automatic logic [8:0] coin_value(input coin_t c);
    logic [8:0] v;
    case (c)
      COIN_Q:  v = 9'd25;
      COIN_D:  v = 9'd10;
      COIN_N:  v = 9'd5;
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  // Coin choice and arithmetic for the next state and outputs.
  always_comb begin
    pick_s       = pick_coin(remaining_r, tube_empty_q, tube_empty_d, tube_empty_n);
    coin_val_s   = coin_value(coin_r);
    rem_after_s  = remaining_r;
    ncoins_inc_s = ncoins;
    // The guard is defensive: a coin is only ever chosen when it fits.
    if (coin_val_s <= remaining_r) begin
      rem_after_s = remaining_r - coin_val_s;
    end else begin
      rem_after_s = remaining_r;
    end
    if (ncoins == 7'd127) begin
      ncoins_inc_s = ncoins;
    end else begin
      ncoins_inc_s = ncoins + 7'd1;
    end
  end

  // Sequencer FSM. All outputs are registered here. Pulse outputs default
  // low each cycle and are raised only on the transition into the state
  // where they belong.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      coin_r      <= COIN_NONE;
      remaining_r <= 9'd0;
      wait_cnt_r  <= {CW{1'b0}};
      eject_q     <= 1'b0;
      eject_d     <= 1'b0;
      eject_n     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      shortfall   <= 9'd0;
      ncoins      <= 7'd0;
      err_timeout <= 1'b0;
    end else begin
      eject_q <= 1'b0;
      eject_d <= 1'b0;
      eject_n <= 1'b0;
      done    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            remaining_r <= amount;
            ncoins      <= 7'd0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            state_r     <= S_SELECT;
          end else begin
            busy <= 1'b0;
          end
        end

        S_SELECT: begin
          coin_r     <= pick_s;
          wait_cnt_r <= {CW{1'b0}};
          if (pick_s == COIN_NONE) begin
            done      <= 1'b1;
            shortfall <= remaining_r;
            state_r   <= S_DONE;
          end else begin
            eject_q <= (pick_s == COIN_Q);
            eject_d <= (pick_s == COIN_D);
            eject_n <= (pick_s == COIN_N);
            state_r <= S_EJECT;
          end
        end

        S_EJECT: begin
          wait_cnt_r <= {CW{1'b0}};
          state_r    <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          // An acknowledge on the last waiting cycle still counts.
          if (eject_ack) begin
            remaining_r <= rem_after_s;
            ncoins      <= ncoins_inc_s;
            state_r     <= S_SELECT;
          end else if (wait_cnt_r >= TMO_LAST) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            shortfall   <= remaining_r;
            state_r     <= S_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_eject_sequencer.sv
// Directed bench for coin_eject_sequencer. It uses a table of whole dispense
// sequences with hand-computed expectations, plus hand-written reset
// sequences. Coin pulse order is packed as 2-bit codes (1=q, 2=d, 3=n),
// first coin in the lowest bits.
module tb_coin_eject_sequencer;

  localparam int ACK_TIMEOUT = 15;
  localparam int CYC_LIMIT   = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] amount = 9'd0;
  logic       tube_empty_q = 1'b0;
  logic       tube_empty_d = 1'b0;
  logic       tube_empty_n = 1'b0;
  logic       eject_ack = 1'b0;
  logic       eject_q, eject_d, eject_n, busy, done, err_timeout;
  logic [8:0] shortfall;
  logic [6:0] ncoins;

  int n_checks = 0;
  int n_fail   = 0;

  coin_eject_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .tube_empty_q(tube_empty_q), .tube_empty_d(tube_empty_d), .tube_empty_n(tube_empty_n),
    .eject_ack(eject_ack), .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
    .busy(busy), .done(done), .shortfall(shortfall), .ncoins(ncoins),
    .err_timeout(err_timeout)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  amount;
    logic        eq, ed, en;
    int          delay;     // ack on this WAIT_ACK cycle index (0 = first); 255 = never
    logic        stray;     // also raise ack during the EJECT cycle
    logic        spam;      // hold start high with amount=100 while busy
    logic [63:0] seq;
    int          npulses;
    logic [6:0]  nc;
    logic [8:0]  sf;
    logic        err;
    int          done_cyc;  // cycle of done, counting the SELECT after start as 1
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [8:0] a, input logic eq, input logic ed,
                              input logic en, input int dl, input logic st, input logic sp,
                              input logic [63:0] sq, input int np, input logic [6:0] nc,
                              input logic [8:0] sf, input logic er, input int dc);
    vec_t v;
    v.amount = a; v.eq = eq; v.ed = ed; v.en = en; v.delay = dl; v.stray = st;
    v.spam = sp; v.seq = sq; v.npulses = np; v.nc = nc; v.sf = sf; v.err = er;
    v.done_cyc = dc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {eject_q, eject_d, eject_n, busy, done, err_timeout}, 64'd0);
    check({name, "_shortfall"}, 64'(shortfall), 64'd0);
    check({name, "_ncoins"}, 64'(ncoins), 64'd0);
  endtask

  // Runs one complete sequence. The call starts just after a negedge and
  // returns just after the negedge that follows the done cycle.
  task automatic run_vec(input vec_t v, input string name);
    logic [63:0] seq;
    logic [1:0]  code;
    logic        waiting, got_done;
    int          np, wcnt, done_cyc, last_ej;
    tube_empty_q = v.eq; tube_empty_d = v.ed; tube_empty_n = v.en;
    amount = v.amount; start = 1'b1; eject_ack = 1'b0;
    seq = 64'd0; np = 0; wcnt = 0; done_cyc = 0; last_ej = 0;
    waiting = 1'b0; got_done = 1'b0;
    for (int cyc = 1; cyc <= CYC_LIMIT && !got_done; cyc++) begin
      @(negedge clk);
      start  = v.spam;
      amount = v.spam ? 9'd100 : v.amount;
      check({name, "_onehot"}, 64'($countones({eject_q, eject_d, eject_n}) <= 1), 64'd1);
      check({name, "_busy"}, 64'(busy), 64'd1);
      code = eject_q ? 2'd1 : (eject_d ? 2'd2 : (eject_n ? 2'd3 : 2'd0));
      eject_ack = 1'b0;
      if (code != 2'd0) begin
        if (np < 32) seq[2*np +: 2] = code;
        if (v.delay == 0 && np > 0) check({name, "_coin_gap"}, 64'(cyc - last_ej), 64'd3);
        last_ej = cyc;
        np++;
        waiting = 1'b1;
        wcnt = 0;
        eject_ack = v.stray;
      end else if (waiting) begin
        if (wcnt == v.delay) begin
          eject_ack = 1'b1;
          waiting = 1'b0;
        end
        wcnt++;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        start = 1'b0;
        eject_ack = 1'b0;
        check({name, "_shortfall"}, 64'(shortfall), 64'(v.sf));
        check({name, "_ncoins"}, 64'(ncoins), 64'(v.nc));
        check({name, "_err_timeout"}, 64'(err_timeout), 64'(v.err));
      end
    end
    start = 1'b0;
    eject_ack = 1'b0;
    if (!got_done) begin
      check({name, "_done_within_budget"}, 64'd0, 64'd1);
    end else begin
      check({name, "_npulses"}, 64'(np), 64'(v.npulses));
      check({name, "_pulse_order"}, seq, v.seq);
      check({name, "_done_cycle"}, 64'(done_cyc), 64'(v.done_cyc));
      @(negedge clk);
      check({name, "_done_single"}, 64'(done), 64'd0);
      check({name, "_idle_busy"}, 64'(busy), 64'd0);
      check({name, "_err_sticky"}, 64'(err_timeout), 64'(v.err));
      check({name, "_shortfall_hold"}, 64'(shortfall), 64'(v.sf));
    end
  endtask

  initial begin
    int  wait_cycles;
    logic seen_done;

    //            amt   q  d  n  dly st sp  seq                     np  nc  sf  err dc
    vecs[0]  = mk(9'd65,  0, 0, 0, 0,  0, 0, 64'hE5,                 4,  4, 0,  0, 14);
    vecs[1]  = mk(9'd40,  1, 0, 0, 0,  0, 0, 64'hAA,                 4,  4, 0,  0, 14);
    vecs[2]  = mk(9'd37,  0, 0, 0, 0,  0, 0, 64'h9,                  2,  2, 2,  0, 8);
    vecs[3]  = mk(9'd0,   0, 0, 0, 0,  0, 0, 64'h0,                  0,  0, 0,  0, 2);
    vecs[4]  = mk(9'd511, 0, 0, 0, 0,  0, 0, 64'h0000_0255_5555_5555, 21, 21, 1,  0, 65);
    vecs[5]  = mk(9'd30,  1, 1, 1, 0,  0, 0, 64'h0,                  0,  0, 30, 0, 2);
    vecs[6]  = mk(9'd14,  0, 0, 1, 0,  0, 0, 64'h2,                  1,  1, 4,  0, 5);
    vecs[7]  = mk(9'd25,  0, 0, 0, ACK_TIMEOUT-1, 0, 0, 64'h1,       1,  1, 0,  0, 19);
    vecs[8]  = mk(9'd5,   1, 1, 0, 0,  0, 0, 64'h3,                  1,  1, 0,  0, 5);
    vecs[9]  = mk(9'd10,  0, 0, 0, 2,  1, 0, 64'h2,                  1,  1, 0,  0, 7);
    vecs[10] = mk(9'd30,  0, 0, 0, 0,  0, 1, 64'hD,                  2,  2, 0,  0, 8);
    vecs[11] = mk(9'd25,  0, 0, 0, 255, 0, 0, 64'h1,                 1,  0, 25, 1, 18);

    // Reset held: everything reads zero.
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    reset = 1'b0;

    // The first table entry starts on the very first cycle after reset.
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d_amt%0d", i, vecs[i].amount));
    end

    // Reset during the first WAIT_ACK of a 50-cent sequence.
    tube_empty_q = 1'b0; tube_empty_d = 1'b0; tube_empty_n = 1'b0;
    amount = 9'd50; start = 1'b1;
    wait_cycles = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      wait_cycles++;
    end while (!eject_q && wait_cycles < 20);
    check("midreset_saw_eject_q", 64'(eject_q), 64'd1);
    @(negedge clk);
    check("midreset_busy_before", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1 check_all_zero("midreset_immediate");
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      seen_done = seen_done | done | busy;
    end
    check("midreset_no_done", 64'(seen_done), 64'd0);

    // A fresh start after the aborted sequence still works normally.
    run_vec(mk(9'd10, 0, 0, 0, 0, 0, 0, 64'h2, 1, 1, 0, 0, 5), "after_reset_amt10");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
